exception_unit: RTL and testbench

//  Producer side of the 70-bit exception bus consumed by coprocessor 0. Collects

---
 rtl/exception_unit_pkg.sv | 55 +++++
 rtl/exception_unit_exc_priority_enc.sv | 23 ++
 rtl/exception_unit.sv | 122 ++++++++++++
 tb/tb_exception_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exception_unit_pkg.sv
// Shared exception bus layout, flag priority order, FSM encoding and stage tag types.
// Flag vectors use bus order: index i corresponds to bus bit EXC_OFF_ADDRL + i.
package exception_unit_pkg;

  localparam int EXC_W         = 70;
  localparam int EXC_OFF_TR    = 69;
  localparam int EXC_OFF_OVF   = 68;
  localparam int EXC_OFF_RI    = 67;
  localparam int EXC_OFF_SYS   = 66;
  localparam int EXC_OFF_ADDRS = 65;
  localparam int EXC_OFF_ADDRL = 64;
  localparam int EXC_OFF_EPC   = 32;
  localparam int EXC_OFF_BADVA = 0;

  localparam int NFLAG     = 6;
  localparam int F_ADDRL   = EXC_OFF_ADDRL - EXC_OFF_ADDRL;
  localparam int F_ADDRS   = EXC_OFF_ADDRS - EXC_OFF_ADDRL;
  localparam int F_SYSCALL = EXC_OFF_SYS   - EXC_OFF_ADDRL;
  localparam int F_RI      = EXC_OFF_RI    - EXC_OFF_ADDRL;
  localparam int F_OVF     = EXC_OFF_OVF   - EXC_OFF_ADDRL;
  localparam int F_TR      = EXC_OFF_TR    - EXC_OFF_ADDRL;

  // Highest priority first.
  localparam int PRIO [NFLAG] = '{F_RI, F_SYSCALL, F_OVF, F_TR, F_ADDRL, F_ADDRS};

  typedef logic [NFLAG-1:0] flags_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SIGNAL = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        ri;
    logic        syscall;
    logic [31:0] pc;
  } ex_tag_t;

  typedef struct packed {
    logic        valid;
    logic        ri;
    logic        syscall;
    logic        ovf;
    logic        tr;
    logic [31:0] pc;
  } mem_tag_t;

  function automatic logic [EXC_W-1:0] pack_bus(flags_t f, logic [31:0] epc,
                                                logic [31:0] badva);
    return {f, epc, badva};
  endfunction

endpackage

// File: rtl/exception_unit_exc_priority_enc.sv
// Picks the single highest-priority raised flag; one-hot out, all-zero when none.
// Purely combinational, no backpressure.
module exc_priority_enc
  import exception_unit_pkg::*;
(
  input  flags_t flags,
  output flags_t win
);

  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NFLAG; i++) begin
      if (!found && flags[PRIO[i]]) begin
        win[PRIO[i]] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Carries ID/EX/MEM exception flags to the MEM commit point and pulses the CP0 bus.
// Bus pulse one cycle after detection, then flush for FLUSH_CYCLES; stall freezes tags.
module exception_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int EXC_W        = 70
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_valid,
  input  logic             id_ri,
  input  logic             id_syscall,
  input  logic [31:0]      id_pc,
  input  logic             ex_ovf,
  input  logic             ex_tr,
  input  logic             mem_addrl,
  input  logic             mem_addrs,
  input  logic [31:0]      mem_addr,
  input  logic             exl,
  output logic [EXC_W-1:0] exception_bus,
  output logic             flush_all,
  output logic             busy
);
  import exception_unit_pkg::*;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t           state_q, state_d;
  ex_tag_t          ex_q, ex_d;
  mem_tag_t         mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXC_W-1:0] bus_q, bus_d;
  logic             flush_q, flush_d;
  logic             busy_q, busy_d;
  flags_t           raw, win;
  logic             detect;

  // Address faults only count for a real instruction sitting in MEM.
  assign raw = {mem_q.tr, mem_q.ovf, mem_q.ri, mem_q.syscall,
                mem_q.valid & mem_addrs, mem_q.valid & mem_addrl};

  exc_priority_enc u_enc (
    .flags (raw),
    .win   (win)
  );

  assign detect = (state_q == S_IDLE) && !stall && !exl && (|raw);

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (flush_q) begin
      ex_d  = '0;
      mem_d = '0;
    end else if (!stall) begin
      ex_d        = '0;
      if (id_valid) begin
        ex_d.valid   = 1'b1;
        ex_d.ri      = id_ri;
        ex_d.syscall = id_syscall;
        ex_d.pc      = id_pc;
      end
      mem_d.valid   = ex_q.valid;
      mem_d.ri      = ex_q.ri;
      mem_d.syscall = ex_q.syscall;
      mem_d.ovf     = ex_q.valid & ex_ovf;
      mem_d.tr      = ex_q.valid & ex_tr;
      mem_d.pc      = ex_q.pc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (detect) begin
          state_d = S_SIGNAL;
          bus_d   = pack_bus(win, mem_q.pc,
                             (win[F_ADDRL] | win[F_ADDRS]) ? mem_addr : 32'd0);
        end
      end
      S_SIGNAL: begin
        state_d = S_DRAIN;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    flush_d = (state_d != S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ex_q    <= '0;
      mem_q   <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
    end
  end

  assign exception_bus = bus_q;
  assign flush_all     = flush_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: per-cycle vector table plus hand-written reset sequence.
module tb_exception_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, id_valid, id_ri, id_syscall;
  logic [31:0] id_pc;
  logic        ex_ovf, ex_tr, mem_addrl, mem_addrs;
  logic [31:0] mem_addr;
  logic        exl;
  logic [69:0] exception_bus;
  logic        flush_all, busy;

  int total = 0;
  int bad   = 0;

  exception_unit #(.FLUSH_CYCLES(2), .EXC_W(70)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .id_valid      (id_valid),
    .id_ri         (id_ri),
    .id_syscall    (id_syscall),
    .id_pc         (id_pc),
    .ex_ovf        (ex_ovf),
    .ex_tr         (ex_tr),
    .mem_addrl     (mem_addrl),
    .mem_addrs     (mem_addrs),
    .mem_addr      (mem_addr),
    .exl           (exl),
    .exception_bus (exception_bus),
    .flush_all     (flush_all),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          idv, ri, sc;
    logic [31:0] pc;
    bit          ovf, tr, al, as;
    logic [31:0] addr;
    bit          st, ex;
    logic [69:0] bus;
    bit          fl, by;
  } vec_t;

  vec_t tbl[$];
  localparam logic [69:0] Z = 70'd0;

  function automatic vec_t v(bit idv, bit ri, bit sc, logic [31:0] pc,
                             bit ovf, bit tr, bit al, bit as, logic [31:0] addr,
                             bit st, bit ex, logic [69:0] bus, bit fl, bit by);
    vec_t r;
    r.idv = idv; r.ri = ri; r.sc = sc; r.pc = pc;
    r.ovf = ovf; r.tr = tr; r.al = al; r.as = as; r.addr = addr;
    r.st = st; r.ex = ex; r.bus = bus; r.fl = fl; r.by = by;
    return r;
  endfunction

  function automatic vec_t idle(logic [69:0] bus, bit fl, bit by);
    return v(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, bus, fl, by);
  endfunction

  function automatic logic [69:0] B(int flag_bit, logic [31:0] epc, logic [31:0] badva);
    logic [69:0] r;
    r           = '0;
    r[flag_bit] = 1'b1;
    r[63:32]    = epc;
    r[31:0]     = badva;
    return r;
  endfunction

  task automatic chk(string nm, logic [69:0] act, logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t r);
    id_valid = r.idv; id_ri = r.ri; id_syscall = r.sc; id_pc = r.pc;
    ex_ovf = r.ovf; ex_tr = r.tr; mem_addrl = r.al; mem_addrs = r.as;
    mem_addr = r.addr; stall = r.st; exl = r.ex;
  endtask

  task automatic chk_out(string nm, logic [69:0] bus, bit fl, bit by);
    chk({nm, " bus"},   exception_bus, bus);
    chk({nm, " flush"}, {69'd0, flush_all}, {69'd0, fl});
    chk({nm, " busy"},  {69'd0, busy}, {69'd0, by});
  endtask

  task automatic pulse_tail();
    tbl.push_back(idle(Z, 1, 1));
    tbl.push_back(idle(Z, 1, 1));
    tbl.push_back(idle(Z, 0, 0));
  endtask

  initial begin
    // RI in ID reaches MEM two edges later and pulses on the third
    tbl.push_back(v(1,1,0,32'h0040_0010, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(idle(B(67, 32'h0040_0010, 32'h0), 1, 1));
    pulse_tail();
    // misaligned load: BADVA is the effective address
    tbl.push_back(v(1,0,0,32'h0000_0100, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,1,0,32'h1000_0003, 0,0, B(64, 32'h100, 32'h1000_0003),1,1));
    pulse_tail();
    // OVF in EX and ADDRS in MEM together: only the older store reports
    tbl.push_back(v(1,0,0,32'h0000_0010, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(1,0,0,32'h0000_0014, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 1,0,0,1,32'h2000_0001, 0,0, B(65, 32'h10, 32'h2000_0001),1,1));
    pulse_tail();
    tbl.push_back(idle(Z, 0, 0));
    // nested SYSCALL with exl=1 is dropped
    tbl.push_back(v(1,0,1,32'h0000_0200, 0,0,0,0,32'h0, 0,1, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,0,0,32'h0, 0,1, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,0,0,32'h0, 0,1, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,0,0,32'h0, 0,1, Z,0,0));
    // RI on a bubble never enters the tags
    tbl.push_back(v(0,1,0,32'h0000_0250, 0,0,0,0,32'h0, 0,0, Z,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(idle(Z, 0, 0));
    // RI held in ID under stall for 4 cycles
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(1,1,0,32'h0000_0300, 0,0,0,0,32'h0, 1,0, Z,0,0));
    tbl.push_back(v(1,1,0,32'h0000_0300, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(idle(B(67, 32'h300, 32'h0), 1, 1));
    pulse_tail();
    // stall blocks detection while RI sits in MEM
    tbl.push_back(v(1,1,0,32'h0000_0400, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,0,0,32'h0, 1,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,0,0,32'h0, 1,0, Z,0,0));
    tbl.push_back(idle(B(67, 32'h400, 32'h0), 1, 1));
    pulse_tail();
    // priority: RI over SYSCALL/TR/ADDRL
    tbl.push_back(v(1,1,1,32'h0000_0500, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,1,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,1,0,32'h0000_0007, 0,0, B(67, 32'h500, 32'h0),1,1));
    pulse_tail();
    // SYSCALL over OVF
    tbl.push_back(v(1,0,1,32'h0000_0600, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 1,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(B(66, 32'h600, 32'h0), 1, 1));
    pulse_tail();
    // OVF over TR and ADDRS; BADVA stays 0
    tbl.push_back(v(1,0,0,32'h0000_0700, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 1,1,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,0,1,32'h0000_0003, 0,0, B(68, 32'h700, 32'h0),1,1));
    pulse_tail();
    // TR over ADDRL
    tbl.push_back(v(1,0,0,32'h0000_0800, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,1,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,1,0,32'h0000_0011, 0,0, B(69, 32'h800, 32'h0),1,1));
    pulse_tail();
    // ADDRL over ADDRS
    tbl.push_back(v(1,0,0,32'h0000_0900, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(v(0,0,0,32'h0, 0,0,1,1,32'h0000_0012, 0,0, B(64, 32'h900, 32'h12),1,1));
    pulse_tail();
    // EX flags on an EX bubble are ignored
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(v(0,0,0,32'h0, 1,1,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(idle(Z, 0, 0));
    // ID RI raised together with MEM ADDRL: MEM wins, RI flushed
    tbl.push_back(v(1,0,0,32'h0000_0A00, 0,0,0,0,32'h0, 0,0, Z,0,0));
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(v(1,1,0,32'h0000_0A10, 0,0,1,0,32'h0000_0021, 0,0, B(64, 32'hA00, 32'h21),1,1));
    pulse_tail();
    tbl.push_back(idle(Z, 0, 0));
    tbl.push_back(idle(Z, 0, 0));

    drive(idle(Z, 0, 0));
    reset = 1'b1;
    step();
    step();
    chk_out("reset", Z, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].bus, tbl[i].fl, tbl[i].by);
    end

    // reset in DRAIN, then a fresh TR
    drive(v(1,1,0,32'h0000_0B00, 0,0,0,0,32'h0, 0,0, Z,0,0));
    step();
    drive(idle(Z, 0, 0));
    step();
    step();
    chk_out("rst_pulse", B(67, 32'hB00, 32'h0), 1, 1);
    step();
    chk_out("rst_drain", Z, 1, 1);
    reset = 1'b1;
    step();
    chk_out("rst_mid", Z, 0, 0);
    reset = 1'b0;
    step();
    chk_out("rst_after", Z, 0, 0);
    drive(v(1,0,0,32'h0000_0C00, 0,0,0,0,32'h0, 0,0, Z,0,0));
    step();
    drive(v(0,0,0,32'h0, 0,1,0,0,32'h0, 0,0, Z,0,0));
    step();
    drive(idle(Z, 0, 0));
    step();
    chk_out("tr_pulse", B(69, 32'hC00, 32'h0), 1, 1);
    step();
    chk_out("tr_drain1", Z, 1, 1);
    step();
    chk_out("tr_drain2", Z, 1, 1);
    step();
    chk_out("tr_idle", Z, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
